// File: rtl/dev_id_reg_bridge_pkg.sv
// Shared definitions for the device-ID/version register bridge: FSM encoding,
// abort read-data pattern and default request timeout.
package dev_id_reg_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2,
        GAP  = 2'd3
    } state_e;

    localparam logic [31:0]  DEAD_BEEF       = 32'hdead_beef;
    localparam int unsigned  DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/dev_id_reg_bridge.sv
// Host-pulse to level-request/one-cycle-ack bridge for the device-ID register slave.
// Optional abort of unacknowledged requests under DEV_ID_REG_BRIDGE_TIMEOUT_EN.
module dev_id_reg_bridge
    import dev_id_reg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 6,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_req,
    input  logic                  host_rd_wr_L,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wr_data,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rd_data,
    output logic                  host_busy,
    output logic                  host_timeout,
    output logic                  reg_req,
    output logic                  reg_rd_wr_L,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    input  logic                  reg_ack,
    input  logic [DATA_WIDTH-1:0] reg_rd_data
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("dev_id_reg_bridge: TIMEOUT_CYCLES must be within 2..65535");
    end

    state_e state;

`ifdef DEV_ID_REG_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
`else
    assign host_timeout = 1'b0;
`endif

    // Transaction FSM; GAP keeps reg_req low one extra cycle so the slave re-arms.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            host_ack     <= 1'b0;
            host_rd_data <= '0;
            host_busy    <= 1'b0;
            reg_req      <= 1'b0;
            reg_rd_wr_L  <= 1'b0;
            reg_addr     <= '0;
            reg_wr_data  <= '0;
`ifdef DEV_ID_REG_BRIDGE_TIMEOUT_EN
            tmo_cnt      <= '0;
            host_timeout <= 1'b0;
`endif
        end else begin
            host_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_req) begin
                        reg_rd_wr_L <= host_rd_wr_L;
                        reg_addr    <= host_addr;
                        reg_wr_data <= host_wr_data;
                        reg_req     <= 1'b1;
                        host_busy   <= 1'b1;
                        state       <= REQ;
`ifdef DEV_ID_REG_BRIDGE_TIMEOUT_EN
                        tmo_cnt      <= '0;
                        host_timeout <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (reg_ack) begin
                        host_rd_data <= reg_rd_data;
                        reg_req      <= 1'b0;
                        host_ack     <= 1'b1;
                        state        <= DONE;
                    end
`ifdef DEV_ID_REG_BRIDGE_TIMEOUT_EN
                    // A late ack on the final count still wins over the abort.
                    else if (tmo_cnt == TMO_LAST) begin
                        host_rd_data <= DATA_WIDTH'(DEAD_BEEF);
                        host_timeout <= 1'b1;
                        reg_req      <= 1'b0;
                        host_ack     <= 1'b1;
                        state        <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                DONE: begin
                    state <= GAP;
                end
                GAP: begin
                    host_busy <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
